// File: rtl/video_mnist_digit_histogram.sv
// Per-frame class histogram of the segmented MNIST stream.
// Counts are banked and scanned for the dominant digit each frame.
module video_mnist_digit_histogram #(
    parameter int   TUSER_WIDTH   = 1,
    parameter int   TNUMBER_WIDTH = 4,
    parameter int   TCOUNT_WIDTH  = 1,
    parameter int   COUNT_WIDTH   = 20,
    parameter int   WB_ADR_WIDTH  = 8,
    parameter int   WB_DAT_WIDTH  = 32,
    parameter logic INIT_ENABLE   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [TUSER_WIDTH-1:0]    s_axi4s_tuser,
    input  logic                      s_axi4s_tlast,
    input  logic [TNUMBER_WIDTH-1:0]  s_axi4s_tnumber,
    input  logic [TCOUNT_WIDTH-1:0]   s_axi4s_tcount,
    input  logic                      s_axi4s_tvalid,
    output logic                      s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]    m_axi4s_tuser,
    output logic                      m_axi4s_tlast,
    output logic [TNUMBER_WIDTH-1:0]  m_axi4s_tnumber,
    output logic [TCOUNT_WIDTH-1:0]   m_axi4s_tcount,
    output logic                      m_axi4s_tvalid,
    input  logic                      m_axi4s_tready,
    input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
    input  logic                      s_wb_we_i,
    input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
    input  logic                      s_wb_stb_i,
    output logic                      s_wb_ack_o
);

    localparam int NUM_CLASSES = 11;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [WB_ADR_WIDTH-1:0] ADR_STATUS    = WB_ADR_WIDTH'(0);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CONTROL   = WB_ADR_WIDTH'(1);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_FRAMES    = WB_ADR_WIDTH'(2);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_MAX_INDEX = WB_ADR_WIDTH'(3);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_MAX_VALUE = WB_ADR_WIDTH'(4);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_BANK      = WB_ADR_WIDTH'(16);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_BANK_LAST = WB_ADR_WIDTH'(26);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, state_next;

    logic [COUNT_WIDTH-1:0] run  [NUM_CLASSES];
    logic [COUNT_WIDTH-1:0] bank [NUM_CLASSES];
    logic [31:0]            frame_count;
    logic [3:0]             idx, best, max_index;
    logic [COUNT_WIDTH-1:0] best_value, max_value;
    logic                   seen_frame, result_valid, enable;

    logic beat, frame_start, countable, load;
    logic wb_write, status_read, clear, busy;
    logic [WB_DAT_WIDTH-1:0] rdata;
    logic unused_wb;

    assign m_axi4s_tuser   = s_axi4s_tuser;
    assign m_axi4s_tlast   = s_axi4s_tlast;
    assign m_axi4s_tnumber = s_axi4s_tnumber;
    assign m_axi4s_tcount  = s_axi4s_tcount;
    assign m_axi4s_tvalid  = s_axi4s_tvalid;
    assign s_axi4s_tready  = m_axi4s_tready;

    assign beat        = s_axi4s_tvalid && m_axi4s_tready;
    assign frame_start = beat && s_axi4s_tuser[0];
    assign countable   = enable && (s_axi4s_tcount != '0)
                         && (s_axi4s_tnumber <= TNUMBER_WIDTH'(10));
    assign wb_write    = s_wb_stb_i && s_wb_we_i;
    assign status_read = s_wb_stb_i && !s_wb_we_i && (s_wb_adr_i == ADR_STATUS);
    assign clear       = wb_write && (s_wb_adr_i == ADR_CONTROL) && s_wb_dat_i[1];
    assign load        = frame_start && seen_frame && !clear;
    assign busy        = (state != IDLE);

    // The frame-start beat restarts the bins and is itself the first pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CLASSES; k++) run[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                if (clear)
                    run[k] <= '0;
                else if (frame_start)
                    run[k] <= (countable && s_axi4s_tnumber == TNUMBER_WIDTH'(k))
                              ? COUNT_WIDTH'(1) : '0;
                else if (beat && countable && s_axi4s_tnumber == TNUMBER_WIDTH'(k)
                         && run[k] != COUNT_MAX)
                    run[k] <= run[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CLASSES; k++) bank[k] <= '0;
            frame_count <= '0;
            seen_frame  <= 1'b0;
            enable      <= INIT_ENABLE;
        end else begin
            if (wb_write && s_wb_adr_i == ADR_CONTROL)
                enable <= s_wb_dat_i[0];
            if (clear) begin
                for (int k = 0; k < NUM_CLASSES; k++) bank[k] <= '0;
                frame_count <= '0;
                seen_frame  <= 1'b0;
            end else begin
                if (load) begin
                    for (int k = 0; k < NUM_CLASSES; k++) bank[k] <= run[k];
                    frame_count <= frame_count + 1'b1;
                end
                if (frame_start)
                    seen_frame <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            SCAN:    if (idx == 4'd9) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (load)
            state_next = SCAN;
        if (clear)
            state_next = IDLE;
    end

    // bank[0] is loaded on the same edge, so seed from the running bin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            best       <= '0;
            best_value <= '0;
        end else if (load) begin
            idx        <= '0;
            best       <= '0;
            best_value <= run[0];
        end else if (state == SCAN) begin
            if (bank[idx] > best_value) begin
                best       <= idx;
                best_value <= bank[idx];
            end
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_index    <= '0;
            max_value    <= '0;
            result_valid <= 1'b0;
        end else if (clear) begin
            max_index    <= '0;
            max_value    <= '0;
            result_valid <= 1'b0;
        end else if (state == DONE) begin
            max_index    <= best;
            max_value    <= best_value;
            result_valid <= 1'b1;
        end else if (status_read) begin
            result_valid <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (s_wb_adr_i)
            ADR_STATUS:    rdata = WB_DAT_WIDTH'({busy, result_valid});
            ADR_CONTROL:   rdata = WB_DAT_WIDTH'(enable);
            ADR_FRAMES:    rdata = WB_DAT_WIDTH'(frame_count);
            ADR_MAX_INDEX: rdata = WB_DAT_WIDTH'(max_index);
            ADR_MAX_VALUE: rdata = WB_DAT_WIDTH'(max_value);
            default: begin
                if (s_wb_adr_i >= ADR_BANK && s_wb_adr_i <= ADR_BANK_LAST)
                    rdata = WB_DAT_WIDTH'(bank[s_wb_adr_i[3:0]]);
            end
        endcase
    end

    assign s_wb_dat_o = reset ? '0 : rdata;
    assign s_wb_ack_o = s_wb_stb_i && !reset;

    assign unused_wb = &{1'b0, s_wb_sel_i, s_wb_dat_i[WB_DAT_WIDTH-1:2]};

endmodule
